// File: rtl/rx_dfe_lut_pkg.sv
// dfe_package: shared defaults, FSM state type and correction word type for rx_dfe_lut
package dfe_package;
    localparam int DFE_N_TAPS    = 3;
    localparam int DFE_SYM_BITS  = 1;
    localparam int DFE_BANK_BITS = 2;
    localparam int DFE_OUT_WIDTH = 16;
    typedef enum logic [1:0] {DFE_CLEAR, DFE_WARMUP, DFE_RUN} dfe_state_t;
    typedef logic signed [DFE_OUT_WIDTH-1:0] dfe_corr_t;
endpackage

// File: rtl/rx_dfe_lut_ram.sv
// my_ram_sdp: simple dual-port RAM, one write port and one registered read-first read port
module my_ram_sdp #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_q
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end
endmodule

// File: rtl/rx_dfe_lut.sv
// rx_dfe_lut: run-time programmable DFE correction lookup indexed by {bank, symbol history, current symbol}
module rx_dfe_lut import dfe_package::*; #(
    parameter int N_TAPS    = DFE_N_TAPS,
    parameter int SYM_BITS  = DFE_SYM_BITS,
    parameter int BANK_BITS = DFE_BANK_BITS,
    parameter int OUT_WIDTH = DFE_OUT_WIDTH,
    localparam int ADDR_W   = BANK_BITS + SYM_BITS * N_TAPS,
    localparam int BSW      = BANK_BITS > 0 ? BANK_BITS : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SYM_BITS-1:0]  in,
    input  logic [BSW-1:0]       bank_sel,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [OUT_WIDTH-1:0] ld_data,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_valid
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int HW    = N_TAPS > 1 ? SYM_BITS * (N_TAPS - 1) : 1;
    localparam int WW    = N_TAPS > 2 ? $clog2(N_TAPS - 1) : 1;
    dfe_state_t               state_q, state_d;
    logic [ADDR_W:0]          clr_cnt_q, clr_cnt_d;
    logic [WW-1:0]            warm_cnt_q, warm_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [SYM_BITS*N_TAPS-1:0] syms;
    logic [ADDR_W-1:0]        idx, waddr;
    logic [OUT_WIDTH-1:0]     wdata, rdata;
    logic                     we, clearing, clr_done, warm_done;
    always_comb begin
        clearing    = state_q == DFE_CLEAR;
        clr_done    = clr_cnt_q == (ADDR_W+1)'(DEPTH - 1);
        warm_done   = N_TAPS == 1 || int'(warm_cnt_q) == N_TAPS - 2;
        clr_cnt_d   = clearing ? clr_cnt_q + 1'b1 : clr_cnt_q;
        warm_cnt_d  = state_q == DFE_WARMUP && warm_cnt_q != '1 ? warm_cnt_q + 1'b1 : warm_cnt_q;
        state_d     = clearing ? (clr_done ? (N_TAPS == 1 ? DFE_RUN : DFE_WARMUP) : DFE_CLEAR)
                    : (state_q == DFE_WARMUP && warm_done ? DFE_RUN : state_q);
        ld_ready    = !clearing;
        we          = clearing || (ld_valid && ld_ready);
        waddr       = clearing ? clr_cnt_q[ADDR_W-1:0] : ld_addr;
        wdata       = clearing ? '0 : ld_data;
        idx         = ADDR_W'({bank_sel, syms});
        out_valid_d = state_q == DFE_RUN;
        out_valid   = out_valid_q;
        out         = out_valid_q ? rdata : '0;
    end
    // History is held newest symbol in the top slot, so the index reads newest..oldest then `in`
    generate
        if (N_TAPS > 1) begin : g_hist
            logic [HW-1:0] hist_q, hist_d;
            always_comb hist_d = clearing ? hist_q : HW'({in, hist_q} >> SYM_BITS);
            always_ff @(posedge clk or posedge rst)
                if (rst) hist_q <= '0;
                else     hist_q <= hist_d;
            assign syms = {hist_q, in};
        end else begin : g_nohist
            assign syms = in;
        end
    endgenerate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DFE_CLEAR;
            clr_cnt_q   <= '0;
            warm_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            warm_cnt_q  <= warm_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end
    my_ram_sdp #(.AW(ADDR_W), .DW(OUT_WIDTH)) u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (idx),
        .rdata_q (rdata)
    );
endmodule
